// File: rtl/cmd_debouncer.sv
// -----------------------------------------------------------------------------
// cmd_debouncer
//
// Purpose:
//   Turns the three raw push-buttons of the Game of Life board into clean,
//   single-cycle command strobes for the game core. Each button goes through
//   its own pipeline, and all three pipelines run in one clock domain:
//     1. a 2-flop synchroniser (s1, s2),
//     2. a stability counter that accepts a level change only after
//        DEBOUNCE_CYCLES consecutive cycles of disagreement,
//     3. a rising-edge detector on the debounced level, which gives one
//        registered strobe per accepted press.
//
// Optional feature (compile-time macro):
//   CMD_DEBOUNCER_MUTEX_EN
//     Defined   : at most one o_cmd_* is high in any cycle. When several
//                 presses are accepted on the same edge, the priority is
//                 load_cfg_1 > load_cfg_2 > toggle_pause. Losing strobes are
//                 dropped, not deferred.
//     Undefined : the three strobes are independent and may coincide.
//   o_btn_state is the same in both builds.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a change (>= 2)
//   CNT_W            counter width, derived from DEBOUNCE_CYCLES
//
// Ports:
//   clk                 in   system clock
//   rst                 in   synchronous, active-high reset
//   i_btn_toggle_pause  in   raw asynchronous button, 1 = pressed
//   i_btn_load_cfg_1    in   raw asynchronous button, 1 = pressed
//   i_btn_load_cfg_2    in   raw asynchronous button, 1 = pressed
//   o_cmd_toggle_pause  out  one-cycle strobe per accepted press
//   o_cmd_load_cfg_1    out  one-cycle strobe per accepted press
//   o_cmd_load_cfg_2    out  one-cycle strobe per accepted press
//   o_btn_state         out  debounced levels {load_cfg_2, load_cfg_1, toggle_pause}
// -----------------------------------------------------------------------------
module cmd_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_toggle_pause,
  input  logic       i_btn_load_cfg_1,
  input  logic       i_btn_load_cfg_2,
  output logic       o_cmd_toggle_pause,
  output logic       o_cmd_load_cfg_1,
  output logic       o_cmd_load_cfg_2,
  output logic [2:0] o_btn_state
);

  localparam int NUM_BTN = 3;

  // Bit positions inside the packed per-button vectors.
  localparam int IDX_TOGGLE = 0;
  localparam int IDX_CFG1   = 1;
  localparam int IDX_CFG2   = 2;

  // Terminal count. The counter never goes past this value, so it cannot wrap.
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Collect the raw inputs into a vector so the per-button logic can be
  // generated once for all three buttons.
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] db_level;   // debounced level per button
  logic [NUM_BTN-1:0] rise_d;     // press accepted on the coming edge

  assign btn_raw[IDX_TOGGLE] = i_btn_toggle_pause;
  assign btn_raw[IDX_CFG1]   = i_btn_load_cfg_1;
  assign btn_raw[IDX_CFG2]   = i_btn_load_cfg_2;

  // ---------------------------------------------------------------------------
  // Per-button synchroniser and debounce counter
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      logic             s1_q;
      logic             s2_q;
      logic             db_q;
      logic             db_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             differ;
      logic             at_term;

      assign differ  = (s2_q != db_q);
      assign at_term = (cnt_q == CNT_TERM);

      // Counter rules:
      //  - synchronised input agrees with the debounced level: restart.
      //    A short glitch therefore never accumulates.
      //  - disagrees and the count is not yet terminal: keep counting.
      //  - disagrees at the terminal count: accept the new level and restart.
      always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (differ) begin
          if (at_term) begin
            db_d  = s2_q;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_q  <= 1'b0;
          s2_q  <= 1'b0;
          db_q  <= 1'b0;
          cnt_q <= '0;
        end else begin
          s1_q  <= btn_raw[gi];
          s2_q  <= s1_q;
          db_q  <= db_d;
          cnt_q <= cnt_d;
        end
      end

      // A press is accepted when the level is about to flip and the new value
      // is 1. Releases (1 -> 0) flip the level but do not produce a strobe.
      assign rise_d[gi]   = differ & at_term & s2_q;
      assign db_level[gi] = db_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Strobe qualification. When the mutex build is enabled, this picks one
  // winner. Either way the debounced levels above keep updating on their own,
  // so a losing press still counts as "held" and cannot strobe again until it
  // is released.
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] cmd_d;
  logic [NUM_BTN-1:0] cmd_q;

`ifdef CMD_DEBOUNCER_MUTEX_EN
  always_comb begin
    cmd_d = '0;
    if (rise_d[IDX_CFG1]) begin
      cmd_d[IDX_CFG1] = 1'b1;
    end else if (rise_d[IDX_CFG2]) begin
      cmd_d[IDX_CFG2] = 1'b1;
    end else if (rise_d[IDX_TOGGLE]) begin
      cmd_d[IDX_TOGGLE] = 1'b1;
    end
  end
`else
  always_comb begin
    cmd_d = rise_d;
  end
`endif

  // The strobe is set on the same edge that moves db from 0 to 1. The next
  // edge clears it, because rise_d cannot hold for two edges in a row: the
  // counter restarts after every accepted change.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q <= '0;
    end else begin
      cmd_q <= cmd_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_cmd_toggle_pause = cmd_q[IDX_TOGGLE];
  assign o_cmd_load_cfg_1   = cmd_q[IDX_CFG1];
  assign o_cmd_load_cfg_2   = cmd_q[IDX_CFG2];
  assign o_btn_state        = db_level;

endmodule

// File: tb/tb_cmd_debouncer.sv
// -----------------------------------------------------------------------------
// Testbench for cmd_debouncer (DEBOUNCE_CYCLES = 4).
// A reference model runs on every rising edge. It works from the raw samples:
// the debounced level follows the raw value seen two edges earlier, once that
// value has disagreed with the level for D edges in a row. Each expected strobe
// goes into a scoreboard queue. A monitor on the falling edge checks the
// debounced state every cycle and pops one entry whenever the DUT strobes.
// -----------------------------------------------------------------------------
module tb_cmd_debouncer;

  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic [2:0] btn;
  logic       cmd_tp, cmd_c1, cmd_c2;
  logic [2:0] btn_state;

  cmd_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_btn_toggle_pause(btn[0]),
    .i_btn_load_cfg_1  (btn[1]),
    .i_btn_load_cfg_2  (btn[2]),
    .o_cmd_toggle_pause(cmd_tp),
    .o_cmd_load_cfg_1  (cmd_c1),
    .o_cmd_load_cfg_2  (cmd_c2),
    .o_btn_state       (btn_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] cmd;
  } exp_t;

  exp_t sb[$];
  int   asserts = 0;
  int   fails   = 0;
  int   cyc     = 0;
  int   strobes_seen = 0;

  // ---------------- reference model ----------------
  logic       prev1 [3];   // raw value sampled one edge ago
  logic       prev2 [3];   // raw value sampled two edges ago
  int         streak [3];  // consecutive edges the delayed value disagreed with lvl
  logic       lvl [3];
  logic [2:0] exp_state = 3'b000;
  logic [2:0] rises;
  logic [2:0] grant;

  initial begin
    for (int b = 0; b < 3; b++) begin
      prev1[b] = 0; prev2[b] = 0; streak[b] = 0; lvl[b] = 0;
    end
  end

  always @(posedge clk) begin
    cyc++;
    rises = 3'b000;
    for (int b = 0; b < 3; b++) begin
      if (rst) begin
        prev1[b] = 0; prev2[b] = 0; streak[b] = 0; lvl[b] = 0;
      end else begin
        if (prev2[b] != lvl[b]) streak[b]++;
        else streak[b] = 0;
        if (streak[b] == D) begin
          lvl[b] = prev2[b];
          streak[b] = 0;
          if (lvl[b]) rises[b] = 1'b1;
        end
        prev2[b] = prev1[b];
        prev1[b] = btn[b];
      end
    end
`ifdef CMD_DEBOUNCER_MUTEX_EN
    if (rises[1])      grant = 3'b010;
    else if (rises[2]) grant = 3'b100;
    else if (rises[0]) grant = 3'b001;
    else               grant = 3'b000;
`else
    grant = rises;
`endif
    exp_state = {lvl[2], lvl[1], lvl[0]};
    if (grant != 3'b000) sb.push_back('{cyc: cyc, cmd: grant});
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [2:0] dut_cmd;
    exp_t       e;
    if (cyc > 0) begin
      dut_cmd = {cmd_c2, cmd_c1, cmd_tp};
      asserts++;
      if (btn_state !== exp_state) begin
        fails++;
        $display("FAIL btn_state cyc=%0d got=%b exp=%b", cyc, btn_state, exp_state);
      end
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        asserts++;
        fails++;
        $display("FAIL missed_strobe cyc=%0d got=none exp=%b at cyc %0d", cyc, e.cmd, e.cyc);
      end
      if (dut_cmd !== 3'b000) begin
        strobes_seen++;
        asserts++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_strobe cyc=%0d got=%b exp=none", cyc, dut_cmd);
        end else begin
          e = sb.pop_front();
          if (e.cyc != cyc || e.cmd !== dut_cmd) begin
            fails++;
            $display("FAIL strobe cyc=%0d got=%b exp=%b at cyc %0d", cyc, dut_cmd, e.cmd, e.cyc);
          end else begin
            $display("strobe cyc=%0d cmd=%b state=%b ok", cyc, dut_cmd, btn_state);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int hold [3];

  initial begin
    rst = 1'b1;
    btn = 3'b111;
    // reset held for 2 edges with all buttons pressed
    step(2);
    rst = 1'b0;
    step(12);
    btn = 3'b000;
    step(12);

    // clean press on toggle_pause
    btn[0] = 1'b1; step(100);
    btn[0] = 1'b0; step(12);

    // bouncing load_cfg_1, then held
    for (int i = 0; i < 2; i++) begin
      btn[1] = 1'b1; step(2);
      btn[1] = 1'b0; step(2);
    end
    btn[1] = 1'b1; step(20);
    btn[1] = 1'b0; step(12);

    // 3-cycle glitch on load_cfg_2
    btn[2] = 1'b1; step(3);
    btn[2] = 1'b0; step(12);

    // repeat press on toggle_pause
    btn[0] = 1'b1; step(20);
    btn[0] = 1'b0; step(20);
    btn[0] = 1'b1; step(20);
    btn[0] = 1'b0; step(12);

    // simultaneous press
    btn = 3'b111; step(20);
    btn = 3'b000; step(12);

    // reset in the middle of a debounce
    btn = 3'b101; step(3);
    rst = 1'b1; step(1);
    rst = 1'b0; step(15);
    btn = 3'b000; step(12);

    // randomized phase
    for (int b = 0; b < 3; b++) hold[b] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 3; b++) begin
        if (hold[b] == 0) begin
          btn[b] = $urandom_range(0, 1);
          hold[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 14) : $urandom_range(1, 6);
        end
        hold[b]--;
      end
      rst = ($urandom_range(0, 499) == 0);
      step(1);
    end
    rst = 1'b0;
    btn = 3'b000;
    step(20);

    asserts++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
    end
    asserts++;
    if (strobes_seen < 8) begin
      fails++;
      $display("FAIL strobe_activity got=%0d strobes exp>=8", strobes_seen);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
